// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - opcodes, FSM states and alignment helper for mem_ctrl_sync
package mem_ctrl_pkg;

    // SPARC op3[5:0] access opcodes
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    // Low address bits that must be zero; access size in bytes is mask + 1.
    function automatic logic [2:0] align_mask(input logic [5:0] op);
        case (op)
            OP_LD, OP_ST:              return 3'd3;
            OP_LDUH, OP_LDSH, OP_STH:  return 3'd1;
            OP_LDD, OP_STD:            return 3'd7;
            default:                   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// rtl/mem_byte_array.sv - 8-byte-wide synchronous RAM with per-byte write strobes
module mem_byte_array #(
    parameter int ROW_BITS = 6
) (
    input  logic                i_clk,
    input  logic                i_en,
    input  logic [7:0]          i_we,
    input  logic [ROW_BITS-1:0] i_addr,
    input  logic [63:0]         i_wdata,
    output logic [63:0]         o_rdata
);

    logic [63:0] r_mem [0:(1<<ROW_BITS)-1];
    logic [63:0] r_rdata;

    // Strobe bit k writes data bits [8k+7:8k]; read returns the pre-write row contents
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int k = 0; k < 8; k++) begin
                if (i_we[k]) begin
                    r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_ctrl_sync.sv
// rtl/mem_ctrl_sync.sv - four-phase SPARC load/store memory controller; MEM_DWORD_ACCESS_EN enables LDD/STD
module mem_ctrl_sync
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [5:0]  OpCode,
    input  logic [31:0] MAR_Address,
    input  logic [31:0] MDR_DataIn,
    input  logic [31:0] MDR_DataIn2,
    output logic [31:0] MDR_DataOut,
    output logic [31:0] MDR_DataOut2,
    output logic        MFC,
    output logic        MSET,
    output logic        MLET
);

    localparam int ROW_BITS = ADDR_WIDTH - 3;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [5:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_din;
`ifdef MEM_DWORD_ACCESS_EN
    logic [31:0] r_din2;
`endif
    logic        r_mfc, r_mset, r_mlet;
    logic [31:0] r_dout, r_dout2;

    logic        w_is_load, w_is_store, w_sign, w_store_class;
    logic        w_misalign, w_oor, w_err, w_resp, w_arr_en;
    logic [2:0]  w_mask, w_off;
    logic [32:0] w_last;
    logic [7:0]  w_strb_base, w_strb;
    logic [63:0] w_wdata, w_rdata, w_rd_sh;
    logic [31:0] w_ld_data, w_ld_data2;
    logic        w_unused;

    // Classify the latched opcode into legal load / legal store
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_sign     = 1'b0;
        case (r_op)
            OP_LD, OP_LDUB, OP_LDUH: w_is_load = 1'b1;
            OP_LDSB, OP_LDSH: begin
                w_is_load = 1'b1;
                w_sign    = 1'b1;
            end
            OP_ST, OP_STB, OP_STH: w_is_store = 1'b1;
`ifdef MEM_DWORD_ACCESS_EN
            OP_LDD: w_is_load  = 1'b1;
            OP_STD: w_is_store = 1'b1;
`endif
            default: ;
        endcase
    end

    // Store-class opcodes (00x1xx) report errors on MSET, everything else on MLET
    assign w_store_class = (r_op[5:4] == 2'b00) && r_op[2];
    assign w_mask        = align_mask(r_op);
    assign w_off         = r_addr[2:0];
    assign w_misalign    = (w_off & w_mask) != 3'b000;
    // Last byte touched; any address bit above the array also lands here, so one test covers both
    assign w_last        = {1'b0, r_addr} + {30'b0, w_mask};
    assign w_oor         = (w_last >> ADDR_WIDTH) != 33'd0;
    assign w_err         = !(w_is_load || w_is_store) || w_misalign || w_oor;
    assign w_resp        = r_mfc || r_mset || r_mlet;
    assign w_arr_en      = (r_state == S_ACCESS) && !Reset;

    // Replicate store data across the row; the strobe picks the addressed big-endian lanes
    always_comb begin
        w_strb_base = 8'h80;
        w_wdata     = {8{r_din[7:0]}};
        case (w_mask)
            3'd1: begin
                w_strb_base = 8'hC0;
                w_wdata     = {4{r_din[15:0]}};
            end
            3'd3: begin
                w_strb_base = 8'hF0;
                w_wdata     = {2{r_din}};
            end
`ifdef MEM_DWORD_ACCESS_EN
            3'd7: begin
                w_strb_base = 8'hFF;
                w_wdata     = {r_din, r_din2};
            end
`endif
            default: ;
        endcase
    end

    assign w_strb = (w_arr_en && w_is_store && !w_err) ? (w_strb_base >> w_off) : 8'h00;

    mem_byte_array #(
        .ROW_BITS (ROW_BITS)
    ) u_array (
        .i_clk   (Clk),
        .i_en    (w_arr_en),
        .i_we    (w_strb),
        .i_addr  (r_addr[ADDR_WIDTH-1:3]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Move the addressed byte to the top of the row, then right-justify and extend
    assign w_rd_sh = w_rdata << {w_off, 3'b000};

    always_comb begin
        w_ld_data  = w_rd_sh[63:32];
        w_ld_data2 = 32'h0;
        case (w_mask)
            3'd0: w_ld_data = {{24{w_sign & w_rd_sh[63]}}, w_rd_sh[63:56]};
            3'd1: w_ld_data = {{16{w_sign & w_rd_sh[63]}}, w_rd_sh[63:48]};
`ifdef MEM_DWORD_ACCESS_EN
            3'd7: begin
                w_ld_data  = w_rdata[63:32];
                w_ld_data2 = w_rdata[31:0];
            end
`endif
            default: ;
        endcase
    end

`ifdef MEM_DWORD_ACCESS_EN
    assign w_unused = ^w_rd_sh[31:0];
`else
    assign w_unused = ^{w_rd_sh[31:0], MDR_DataIn2};
`endif

    // Next-state: DONE only releases once a response is showing and Enable has dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (Enable) w_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (r_cnt == 4'(WAIT_CYCLES - 1)) w_next = S_ACCESS;
            S_ACCESS: w_next = S_DONE;
            S_DONE:   if (w_resp && !Enable) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + 4'd1 : 4'd0;
        end
    end

    // Capture the request once; later input changes are ignored until the next IDLE
    always_ff @(posedge Clk) begin
        if (!Reset && r_state == S_IDLE && Enable) begin
            r_op   <= OpCode;
            r_addr <= MAR_Address;
            r_din  <= MDR_DataIn;
`ifdef MEM_DWORD_ACCESS_EN
            r_din2 <= MDR_DataIn2;
`endif
        end
    end

    // Response: set in the first DONE cycle from the array read, cleared on handshake release
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mfc   <= 1'b0;
            r_mset  <= 1'b0;
            r_mlet  <= 1'b0;
            r_dout  <= 32'h0;
            r_dout2 <= 32'h0;
        end else if (r_state == S_DONE) begin
            if (!w_resp) begin
                r_mfc  <= !w_err;
                r_mset <= w_err && w_store_class;
                r_mlet <= w_err && !w_store_class;
                if (!w_err && w_is_load) begin
                    r_dout  <= w_ld_data;
                    r_dout2 <= w_ld_data2;
                end
            end else if (!Enable) begin
                r_mfc  <= 1'b0;
                r_mset <= 1'b0;
                r_mlet <= 1'b0;
            end
        end
    end

    assign MFC          = r_mfc;
    assign MSET         = r_mset;
    assign MLET         = r_mlet;
    assign MDR_DataOut  = r_dout;
    assign MDR_DataOut2 = r_dout2;

endmodule

// File: tb/tb_mem_ctrl_sync.sv
// tb/tb_mem_ctrl_sync.sv - randomized self-checking bench for mem_ctrl_sync
module tb_mem_ctrl_sync;

    localparam int AW        = 9;
    localparam int WC        = 2;
    localparam int MEM_BYTES = 1 << AW;

    localparam logic [5:0] C_LD   = 6'b000000;
    localparam logic [5:0] C_LDUB = 6'b000001;
    localparam logic [5:0] C_LDUH = 6'b000010;
    localparam logic [5:0] C_LDD  = 6'b000011;
    localparam logic [5:0] C_ST   = 6'b000100;
    localparam logic [5:0] C_STB  = 6'b000101;
    localparam logic [5:0] C_STH  = 6'b000110;
    localparam logic [5:0] C_STD  = 6'b000111;
    localparam logic [5:0] C_LDSB = 6'b001001;
    localparam logic [5:0] C_LDSH = 6'b001010;

    logic        Clk = 1'b0;
    logic        Reset, Enable;
    logic [5:0]  OpCode;
    logic [31:0] MAR_Address, MDR_DataIn, MDR_DataIn2;
    logic [31:0] MDR_DataOut, MDR_DataOut2;
    logic        MFC, MSET, MLET;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mdl_mem [MEM_BYTES];
    logic [31:0] exp_d1, exp_d2, last_d1, last_d2;
    logic [2:0]  last_flags;
    logic [5:0]  op_list [10];

    mem_ctrl_sync #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Enable       (Enable),
        .OpCode       (OpCode),
        .MAR_Address  (MAR_Address),
        .MDR_DataIn   (MDR_DataIn),
        .MDR_DataIn2  (MDR_DataIn2),
        .MDR_DataOut  (MDR_DataOut),
        .MDR_DataOut2 (MDR_DataOut2),
        .MFC          (MFC),
        .MSET         (MSET),
        .MLET         (MLET)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed big-endian memory, flags as one-hot {MLET,MSET,MFC}
    task automatic model_access(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] din, input logic [31:0] din2,
                                output logic [2:0] eflag);
        int sz;
        bit legal, ld, sx;
        longint unsigned val;
        longint a;
        legal = 1'b1; ld = 1'b0; sx = 1'b0; sz = 1;
        case (op)
            C_LD:   begin sz = 4; ld = 1'b1; end
            C_LDUB: begin sz = 1; ld = 1'b1; end
            C_LDUH: begin sz = 2; ld = 1'b1; end
            C_LDSB: begin sz = 1; ld = 1'b1; sx = 1'b1; end
            C_LDSH: begin sz = 2; ld = 1'b1; sx = 1'b1; end
            C_ST:   sz = 4;
            C_STB:  sz = 1;
            C_STH:  sz = 2;
`ifdef MEM_DWORD_ACCESS_EN
            C_LDD:  begin sz = 8; ld = 1'b1; end
            C_STD:  sz = 8;
`endif
            default: legal = 1'b0;
        endcase
        a = longint'(addr);
        if (!legal || (a % sz) != 0 || (a + sz - 1 > MEM_BYTES - 1)) begin
            eflag = (op[5:4] == 2'b00 && op[2]) ? 3'b010 : 3'b100;
        end else if (!ld) begin
            eflag = 3'b001;
            val = (sz == 8) ? {din, din2} : {32'h0, din};
            for (int i = 0; i < sz; i++) mdl_mem[a + i] = 8'(val >> (8 * (sz - 1 - i)));
        end else begin
            eflag = 3'b001;
            val = 0;
            for (int i = 0; i < sz; i++) val = (val << 8) | {56'h0, mdl_mem[a + i]};
            if (sz == 8) begin
                exp_d1 = val[63:32];
                exp_d2 = val[31:0];
            end else begin
                if (sx && val[8 * sz - 1]) val = val | (~64'd0 << (8 * sz));
                exp_d1 = val[31:0];
                exp_d2 = 32'h0;
            end
        end
    endtask

    // One full four-phase transaction with inputs scrambled after the request is taken
    task automatic run(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] din2, input int hold);
        logic [2:0] eflag, flags;
        int cyc;
        model_access(op, addr, din, din2, eflag);
        @(negedge Clk);
        OpCode = op; MAR_Address = addr; MDR_DataIn = din; MDR_DataIn2 = din2; Enable = 1'b1;
        cyc = 0;
        flags = 3'b000;
        while (cyc < 40) begin
            @(posedge Clk); #1;
            cyc++;
            OpCode = 6'($urandom); MAR_Address = $urandom;
            MDR_DataIn = $urandom; MDR_DataIn2 = $urandom;
            flags = {MLET, MSET, MFC};
            if (flags != 3'b000) break;
        end
        last_flags = flags;
        last_d1 = MDR_DataOut;
        last_d2 = MDR_DataOut2;
        chk("flags", flags, eflag);
        chk("latency", cyc - 1, WC + 2);
        chk("dout", last_d1, exp_d1);
        chk("dout2", last_d2, exp_d2);
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); #1;
            MDR_DataIn = $urandom; MAR_Address = $urandom; OpCode = 6'($urandom);
            chk("hold_flags", {MLET, MSET, MFC}, eflag);
            chk("hold_dout", MDR_DataOut, exp_d1);
        end
        @(negedge Clk);
        Enable = 1'b0;
        @(posedge Clk); #1;
        chk("release", {MLET, MSET, MFC}, 3'b000);
    endtask

    initial begin
        logic [31:0] addr;
        logic [5:0]  op;
        op_list = '{C_LD, C_LDUB, C_LDUH, C_LDSB, C_LDSH, C_ST, C_STB, C_STH, C_LDD, C_STD};
        Reset = 1'b1; Enable = 1'b0; OpCode = '0;
        MAR_Address = '0; MDR_DataIn = '0; MDR_DataIn2 = '0;
        exp_d1 = '0; exp_d2 = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_flags", {MLET, MSET, MFC}, 3'b000);
        chk("rst_dout", MDR_DataOut, 32'h0);
        chk("rst_dout2", MDR_DataOut2, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < MEM_BYTES / 4; i++) run(C_ST, 32'(4 * i), $urandom, 32'h0, 0);

        run(C_ST, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        run(C_LD, 32'h10, 32'h0, 32'h0, 0);
        chk("ld_deadbeef", last_d1, 32'hDEADBEEF);
        chk("ld_mfc", last_flags, 3'b001);

        run(C_STB, 32'h13, 32'h80, 32'h0, 0);
        run(C_LDSB, 32'h13, 32'h0, 32'h0, 0);
        chk("ldsb", last_d1, 32'hFFFFFF80);
        run(C_LDUB, 32'h13, 32'h0, 32'h0, 0);
        chk("ldub", last_d1, 32'h00000080);

        run(C_STH, 32'h11, 32'h1234, 32'h0, 0);
        chk("sth_mset", last_flags, 3'b010);
        run(C_LD, 32'h10, 32'h0, 32'h0, 0);
        chk("sth_no_write", last_d1, 32'hDEADBE80);
        run(C_LD, 32'h1FE, 32'h0, 32'h0, 0);
        chk("ld_oor_mlet", last_flags, 3'b100);
        run(C_LD, 32'h1FC, 32'h0, 32'h0, 0);
        chk("ld_top_mfc", last_flags, 3'b001);

        run(C_STD, 32'h20, 32'h11223344, 32'h55667788, 0);
`ifdef MEM_DWORD_ACCESS_EN
        chk("std_mfc", last_flags, 3'b001);
        run(C_LDD, 32'h20, 32'h0, 32'h0, 0);
        chk("ldd_even", last_d1, 32'h11223344);
        chk("ldd_odd", last_d2, 32'h55667788);
`else
        chk("std_mset", last_flags, 3'b010);
        run(C_LDD, 32'h20, 32'h0, 32'h0, 0);
        chk("ldd_mlet", last_flags, 3'b100);
`endif

        // Reset while the store is still waiting must drop it without a write
        @(negedge Clk);
        OpCode = C_ST; MAR_Address = 32'h30; MDR_DataIn = 32'hCAFEF00D; Enable = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1; Enable = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        exp_d1 = 32'h0; exp_d2 = 32'h0;
        chk("abort_flags", {MLET, MSET, MFC}, 3'b000);
        chk("abort_dout", MDR_DataOut, 32'h0);
        chk("abort_dout2", MDR_DataOut2, 32'h0);
        run(C_LD, 32'h30, 32'h0, 32'h0, 0);

        run(C_ST, 32'h40, 32'h01020304, 32'h0, 5);
        run(C_LD, 32'h40, 32'h0, 32'h0, 0);
        chk("hold_single_write", last_d1, 32'h01020304);

        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0, 1:    addr = 32'($urandom_range(0, MEM_BYTES - 1));
                2:       addr = 32'(MEM_BYTES - 1 - $urandom_range(0, 15));
                default: addr = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) addr[2:0] = 3'b000;
            run(op, addr, $urandom, $urandom, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
